// File: rtl/can_rx_frame_sequencer_if.sv
// Bit-level receive bus between the bit-timing unit and the CAN receive frame sequencer,
// plus the sequencer's CRC-control and decoded-field outputs.
interface can_rx_frame_sequencer_if;
  logic        bitstrobe;
  logic        CANRX;
  logic        abort;
  logic        SOF;
  logic        bitstuff;
  logic        endCRC;
  logic        stopCRC;
  logic [3:0]  pkt_size;
  logic [28:0] rx_id;
  logic        ide;
  logic        rtr;
  logic        stuff_err;
  logic        frame_active;

  modport master (
    output bitstrobe, CANRX, abort,
    input  SOF, bitstuff, endCRC, stopCRC, pkt_size, rx_id, ide, rtr, stuff_err, frame_active
  );

  modport slave (
    input  bitstrobe, CANRX, abort,
    output SOF, bitstuff, endCRC, stopCRC, pkt_size, rx_id, ide, rtr, stuff_err, frame_active
  );
endinterface

// File: rtl/can_rx_frame_sequencer.sv
// Receive-side CAN frame sequencer: follows the bit position in std/ext data frames,
// destuffs the bus, extracts ID/IDE/RTR/DLC and steers the receive CRC checker.
module can_rx_frame_sequencer (
  input logic                     clk,
  input logic                     nRST,
  can_rx_frame_sequencer_if.slave bus
);
  // state     | meaning                 state    | meaning
  // WAIT_IDLE | wait for 11 recessive   RTR_X    | ext-frame RTR bit
  // IDLE      | wait for SOF            R1, R0   | reserved bits
  // ID_A      | 11 base ID bits         DLC      | 4 length bits
  // BIT12     | SRR or RTR (held)       DATA     | data bits
  // IDE_BIT   | IDE bit                 CRC      | 15 CRC bits
  // ID_B      | 18 ext ID bits          CRC_END  | wait for CRC delimiter
  // EOF_WAIT  | ACK, ACK delim, 7 EOF
  typedef enum logic [3:0] {
    WAIT_IDLE, IDLE, ID_A, BIT12, IDE_BIT, ID_B, RTR_X,
    R1, R0, DLC, DATA, CRC, CRC_END, EOF_WAIT
  } state_t;

  localparam logic [5:0] IDLE_BITS_M1 = 6'd10;

  state_t      state, state_n;
  logic [5:0]  cnt, cnt_n;
  logic [2:0]  run, run_n;
  logic        last_bit, last_bit_n;
  logic        held, held_n;
  logic [2:0]  dlc_sh, dlc_sh_n;
  logic        sof_q, sof_n;
  logic        stop_q, stop_n;
  logic        stuff_q, stuff_n;
  logic        endcrc_q, endcrc_n;
  logic        serr_q, serr_n;
  logic        active_q, active_n;
  logic        ide_q, ide_n;
  logic        rtr_q, rtr_n;
  logic [3:0]  pkt_q, pkt_n;
  logic [28:0] id_q, id_n;
  logic [3:0]  dlc_full, dlc_clamp;
  logic [6:0]  data_bits;
  logic        stuffing;

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      state    <= WAIT_IDLE;
      cnt      <= IDLE_BITS_M1;
      run      <= '0;
      last_bit <= 1'b1;
      held     <= 1'b0;
      dlc_sh   <= '0;
      sof_q    <= 1'b0;
      stop_q   <= 1'b0;
      stuff_q  <= 1'b0;
      endcrc_q <= 1'b0;
      serr_q   <= 1'b0;
      active_q <= 1'b0;
      ide_q    <= 1'b0;
      rtr_q    <= 1'b0;
      pkt_q    <= '0;
      id_q     <= '0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      run      <= run_n;
      last_bit <= last_bit_n;
      held     <= held_n;
      dlc_sh   <= dlc_sh_n;
      sof_q    <= sof_n;
      stop_q   <= stop_n;
      stuff_q  <= stuff_n;
      endcrc_q <= endcrc_n;
      serr_q   <= serr_n;
      active_q <= active_n;
      ide_q    <= ide_n;
      rtr_q    <= rtr_n;
      pkt_q    <= pkt_n;
      id_q     <= id_n;
    end
  end

  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    run_n      = run;
    last_bit_n = last_bit;
    held_n     = held;
    dlc_sh_n   = dlc_sh;
    sof_n      = 1'b0;
    stop_n     = 1'b0;
    stuff_n    = stuff_q;
    endcrc_n   = endcrc_q;
    serr_n     = serr_q;
    active_n   = active_q;
    ide_n      = ide_q;
    rtr_n      = rtr_q;
    pkt_n      = pkt_q;
    id_n       = id_q;
    dlc_full   = {dlc_sh, bus.CANRX};
    dlc_clamp  = (dlc_full > 4'd8) ? 4'd8 : dlc_full;
    data_bits  = rtr_q ? 7'd0 : {dlc_clamp, 3'b000};
    stuffing   = (state inside {ID_A, BIT12, IDE_BIT, ID_B, RTR_X, R1, R0, DLC, DATA, CRC});

    if (bus.abort && (state != WAIT_IDLE) && (state != IDLE)) begin
      stop_n   = 1'b1;
      state_n  = WAIT_IDLE;
      cnt_n    = IDLE_BITS_M1;
      stuff_n  = 1'b0;
      endcrc_n = 1'b0;
      active_n = 1'b0;
    end else if (bus.bitstrobe) begin
      if (stuff_q) begin
        // stuff bit: must differ from the run it breaks; field position is frozen
        stuff_n = 1'b0;
        if (bus.CANRX == last_bit) begin
          serr_n   = 1'b1;
          stop_n   = 1'b1;
          active_n = 1'b0;
          endcrc_n = 1'b0;
          state_n  = WAIT_IDLE;
          cnt_n    = IDLE_BITS_M1;
        end else begin
          run_n      = 3'd1;
          last_bit_n = bus.CANRX;
        end
      end else begin
        if (stuffing) begin
          run_n      = (bus.CANRX == last_bit) ? run + 3'd1 : 3'd1;
          last_bit_n = bus.CANRX;
          if (run_n == 3'd5) stuff_n = 1'b1;
        end
        unique case (state)
          WAIT_IDLE: begin
            if (!bus.CANRX)       cnt_n = IDLE_BITS_M1;
            else if (cnt == 6'd0) state_n = IDLE;
            else                  cnt_n = cnt - 6'd1;
          end
          IDLE: begin
            if (!bus.CANRX) begin
              sof_n      = 1'b1;
              id_n       = '0;
              ide_n      = 1'b0;
              rtr_n      = 1'b0;
              pkt_n      = '0;
              serr_n     = 1'b0;
              active_n   = 1'b1;
              run_n      = 3'd1;
              last_bit_n = 1'b0;
              state_n    = ID_A;
              cnt_n      = 6'd10;
            end
          end
          ID_A: begin
            id_n = {id_q[27:0], bus.CANRX};
            if (cnt == 6'd0) state_n = BIT12;
            else             cnt_n = cnt - 6'd1;
          end
          BIT12: begin
            held_n  = bus.CANRX;
            state_n = IDE_BIT;
          end
          IDE_BIT: begin
            ide_n = bus.CANRX;
            if (bus.CANRX) begin
              state_n = ID_B;
              cnt_n   = 6'd17;
            end else begin
              rtr_n   = held;
              state_n = R0;
            end
          end
          ID_B: begin
            id_n = {id_q[27:0], bus.CANRX};
            if (cnt == 6'd0) state_n = RTR_X;
            else             cnt_n = cnt - 6'd1;
          end
          RTR_X: begin
            rtr_n   = bus.CANRX;
            state_n = R1;
          end
          R1: state_n = R0;
          R0: begin
            state_n = DLC;
            cnt_n   = 6'd3;
          end
          DLC: begin
            dlc_sh_n = dlc_full[2:0];
            if (cnt == 6'd0) begin
              pkt_n = dlc_clamp;
              if (data_bits == 7'd0) begin
                state_n = CRC;
                cnt_n   = 6'd14;
              end else begin
                state_n = DATA;
                cnt_n   = 6'(data_bits - 7'd1);
              end
            end else begin
              cnt_n = cnt - 6'd1;
            end
          end
          DATA: begin
            if (cnt == 6'd0) begin
              state_n = CRC;
              cnt_n   = 6'd14;
            end else begin
              cnt_n = cnt - 6'd1;
            end
          end
          CRC: begin
            if (cnt == 6'd0) begin
              state_n  = CRC_END;
              endcrc_n = 1'b1;
            end else begin
              cnt_n = cnt - 6'd1;
            end
          end
          CRC_END: begin
            endcrc_n = 1'b0;
            state_n  = EOF_WAIT;
            cnt_n    = 6'd8;
          end
          EOF_WAIT: begin
            if (cnt == 6'd0) begin
              state_n  = IDLE;
              active_n = 1'b0;
            end else begin
              cnt_n = cnt - 6'd1;
            end
          end
          default: state_n = WAIT_IDLE;
        endcase
      end
    end
  end

  assign bus.SOF          = sof_q;
  assign bus.stopCRC      = stop_q;
  assign bus.bitstuff     = stuff_q;
  assign bus.endCRC       = endcrc_q;
  assign bus.stuff_err    = serr_q;
  assign bus.frame_active = active_q;
  assign bus.ide          = ide_q;
  assign bus.rtr          = rtr_q;
  assign bus.pkt_size     = pkt_q;
  assign bus.rx_id        = id_q;
endmodule

// File: tb/tb_can_rx_frame_sequencer.sv
// Bench for can_rx_frame_sequencer: frames are built and stuffed transmitter-side, and the
// expected per-bit outputs are derived from the stuffed bit image.
module tb_can_rx_frame_sequencer;
  logic clk = 1'b0;
  logic nRST;
  always #5 clk = ~clk;

  can_rx_frame_sequencer_if bus();
  can_rx_frame_sequencer dut (.clk(clk), .nRST(nRST), .bus(bus));

  int n_cmp = 0;
  int n_err = 0;

  // expectations for the cycle after the next clock edge
  logic        nxt_sof = 0, nxt_stop = 0, nxt_stuff = 0, nxt_end = 0, nxt_act = 0, nxt_serr = 0;
  logic        nxt_chk = 1, nxt_ide = 0, nxt_rtr = 0;
  logic [28:0] nxt_id = '0;
  logic [3:0]  nxt_pkt = '0;
  logic        e_sof, e_stop, e_stuff, e_end, e_act, e_serr, e_chk, e_ide, e_rtr;
  logic [28:0] e_id;
  logic [3:0]  e_pkt;

  // transmitted frame image
  logic        tx [0:255];
  logic        st [0:255];
  int          n_tx, n_logical, idx_dlc, idx_crc, idx_delim;
  logic [28:0] f_id;
  logic        f_ide, f_rtr;
  logic [3:0]  f_pkt;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always begin
    @(posedge clk);
    e_sof = nxt_sof; e_stop = nxt_stop; e_stuff = nxt_stuff; e_end = nxt_end;
    e_act = nxt_act; e_serr = nxt_serr; e_chk = nxt_chk; e_id = nxt_id;
    e_ide = nxt_ide; e_rtr = nxt_rtr; e_pkt = nxt_pkt;
    @(negedge clk);
    check("SOF", 32'(bus.SOF), 32'(e_sof));
    check("stopCRC", 32'(bus.stopCRC), 32'(e_stop));
    check("bitstuff", 32'(bus.bitstuff), 32'(e_stuff));
    check("endCRC", 32'(bus.endCRC), 32'(e_end));
    check("frame_active", 32'(bus.frame_active), 32'(e_act));
    check("stuff_err", 32'(bus.stuff_err), 32'(e_serr));
    if (e_chk) begin
      check("rx_id", 32'(bus.rx_id), 32'(e_id));
      check("ide", 32'(bus.ide), 32'(e_ide));
      check("rtr", 32'(bus.rtr), 32'(e_rtr));
      check("pkt_size", 32'(bus.pkt_size), 32'(e_pkt));
    end
  end

  task automatic build_frame(input logic ext, input logic [28:0] id, input logic rtr_b,
                             input logic [3:0] dlc, input logic [63:0] data, input logic [14:0] crc);
    logic q[$];
    int   ndata, lin_dlc, run;
    logic prev;
    q.push_back(1'b0);
    if (!ext) begin
      for (int i = 10; i >= 0; i--) q.push_back(id[i]);
      q.push_back(rtr_b); q.push_back(1'b0); q.push_back(1'b0);
    end else begin
      for (int i = 28; i >= 18; i--) q.push_back(id[i]);
      q.push_back(1'b1); q.push_back(1'b1);
      for (int i = 17; i >= 0; i--) q.push_back(id[i]);
      q.push_back(rtr_b); q.push_back(1'b0); q.push_back(1'b0);
    end
    for (int i = 3; i >= 0; i--) q.push_back(dlc[i]);
    lin_dlc = q.size() - 1;
    f_pkt = (dlc > 4'd8) ? 4'd8 : dlc;
    ndata = rtr_b ? 0 : int'(f_pkt) * 8;
    for (int i = 0; i < ndata; i++) q.push_back(data[63-i]);
    for (int i = 14; i >= 0; i--) q.push_back(crc[i]);
    n_logical = q.size();
    f_id  = ext ? id : {18'b0, id[10:0]};
    f_ide = ext;
    f_rtr = rtr_b;
    n_tx = 0; run = 0; prev = 1'b1;
    for (int i = 0; i < q.size(); i++) begin
      tx[n_tx] = q[i]; st[n_tx] = 1'b0;
      if (i == lin_dlc) idx_dlc = n_tx;
      if (i == q.size() - 1) idx_crc = n_tx;
      n_tx++;
      if (q[i] == prev) run++;
      else begin run = 1; prev = q[i]; end
      if (run == 5) begin
        tx[n_tx] = ~prev; st[n_tx] = 1'b1; n_tx++;
        prev = ~prev; run = 1;
      end
    end
    idx_delim = n_tx;
    tx[n_tx] = 1'b1; st[n_tx] = 1'b0; n_tx++;
    tx[n_tx] = 1'b0; st[n_tx] = 1'b0; n_tx++;
    for (int i = 0; i < 8; i++) begin tx[n_tx] = 1'b1; st[n_tx] = 1'b0; n_tx++; end
  endtask

  task automatic bus_bit(input logic b, input logic ab);
    @(posedge clk); #1;
    bus.bitstrobe = 1'b1; bus.CANRX = b; bus.abort = ab;
  endtask

  task automatic bit_done();
    @(posedge clk); #1;
    bus.bitstrobe = 1'b0; bus.abort = 1'b0; bus.CANRX = 1'b1;
    nxt_sof = 1'b0; nxt_stop = 1'b0;
    repeat ($urandom_range(0, 2)) @(posedge clk);
  endtask

  task automatic send_plain(input logic b, input int n);
    repeat (n) begin bus_bit(b, 1'b0); bit_done(); end
  endtask

  // mode 0: clean frame; 1: corrupt the stuff bit at 'at'; 2: abort with the strobe at 'at'
  task automatic send_frame(input int mode, input int at);
    for (int k = 0; k < n_tx; k++) begin
      logic b;
      b = tx[k];
      if (mode == 1 && k == at) b = ~b;
      bus_bit(b, (mode == 2 && k == at));
      if (mode != 0 && k == at) begin
        nxt_stop = 1'b1; nxt_act = 1'b0; nxt_stuff = 1'b0; nxt_end = 1'b0;
        if (mode == 1) nxt_serr = 1'b1;
        bit_done();
        return;
      end
      nxt_sof = (k == 0);
      if (k == 0) begin nxt_serr = 1'b0; nxt_chk = 1'b0; end
      nxt_stuff = (k + 1 < n_tx) && st[k+1];
      nxt_end   = (k >= idx_crc) && (k < idx_delim);
      nxt_act   = (k < n_tx - 1);
      if (k == idx_dlc) begin
        nxt_chk = 1'b1; nxt_id = f_id; nxt_ide = f_ide; nxt_rtr = f_rtr; nxt_pkt = f_pkt;
      end
      bit_done();
    end
  endtask

  task automatic recover();
    send_plain(1'b1, 10);
    send_plain(1'b0, 1);
    send_plain(1'b1, 11);
  endtask

  initial begin
    #900_000;
    $display("FAIL watchdog: time limit reached before end of test");
    $fatal(1, "timeout");
  end

  initial begin
    int cand[$];
    int mode, at;
    logic ext;
    bus.bitstrobe = 1'b0; bus.CANRX = 1'b1; bus.abort = 1'b0;
    nRST = 1'b0;
    repeat (3) @(posedge clk);
    #1 nRST = 1'b1;

    // leave WAIT_IDLE: a dominant bit restarts the recessive count
    send_plain(1'b1, 3);
    send_plain(1'b0, 1);
    send_plain(1'b1, 11);

    build_frame(1'b0, 29'h123, 1'b0, 4'd2, 64'hA50F_0000_0000_0000, 15'h1234);
    check("std_logical_len", n_logical, 50);
    send_frame(0, 0);
    check("std_rx_id", 32'(bus.rx_id), 32'h123);
    check("std_ide", 32'(bus.ide), 0);
    check("std_pkt", 32'(bus.pkt_size), 2);
    check("std_active_end", 32'(bus.frame_active), 0);

    send_plain(1'b1, 2);
    build_frame(1'b1, 29'h1ABCDEF0, 1'b0, 4'd15, {$urandom, $urandom}, 15'(($urandom)));
    check("ext_logical_len", n_logical, 118);
    send_frame(0, 0);
    check("ext_rx_id", 32'(bus.rx_id), 32'h1ABCDEF0);
    check("ext_ide", 32'(bus.ide), 1);
    check("ext_pkt", 32'(bus.pkt_size), 8);

    build_frame(1'b0, 29'h000, 1'b0, 4'd1, 64'h3C00_0000_0000_0000, 15'h5A5A);
    check("id0_stuff_pos", 32'({st[5], tx[5], st[4]}), 32'b110);
    send_frame(0, 0);
    check("id0_rx_id", 32'(bus.rx_id), 0);
    check("id0_pkt", 32'(bus.pkt_size), 1);

    send_frame(1, 5);
    check("serr_flag", 32'(bus.stuff_err), 1);
    check("serr_active", 32'(bus.frame_active), 0);
    recover();

    build_frame(1'b0, 29'h2F1, 1'b1, 4'd4, 64'hFFFF_FFFF_0000_0000, 15'h0F0F);
    check("rtr_logical_len", n_logical, 34);
    send_frame(0, 0);
    check("rtr_pkt", 32'(bus.pkt_size), 4);
    check("rtr_rtr", 32'(bus.rtr), 1);

    build_frame(1'b0, 29'h55A, 1'b0, 4'd8, {$urandom, $urandom}, 15'h7FFF);
    send_frame(2, idx_dlc + 12);
    check("abort_active", 32'(bus.frame_active), 0);
    check("abort_id_hold", 32'(bus.rx_id), 32'h55A);
    recover();

    for (int f = 0; f < 30; f++) begin
      ext = 1'($urandom_range(0, 1));
      build_frame(ext, ext ? 29'($urandom) : {18'b0, 11'($urandom)}, 1'($urandom_range(0, 3) == 0),
                  4'($urandom), {$urandom, $urandom}, 15'($urandom));
      mode = 0; at = 0;
      case ($urandom_range(0, 5))
        0: begin mode = 2; at = $urandom_range(1, n_tx - 1); end
        1: begin
          cand.delete();
          for (int k = 0; k < n_tx; k++) if (st[k]) cand.push_back(k);
          if (cand.size() > 0) begin mode = 1; at = cand[$urandom_range(0, cand.size() - 1)]; end
        end
        default: ;
      endcase
      send_frame(mode, at);
      if (mode != 0) recover();
      if ($urandom_range(0, 3) == 0) begin bus_bit(1'b1, 1'b1); bit_done(); end
      send_plain(1'b1, $urandom_range(0, 3));
    end

    repeat (4) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
